// File: rtl/card_pkg.sv
// Shared constants and FSM state type for the card hand collector.
// Card indices 52 and 53 are the two jokers.
package card_pkg;

    localparam int NUM_CARDS = 54;
    localparam int CARD_W    = 6;
    localparam int JOKER_LO  = 52;
    localparam int JOKER_HI  = 53;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EMIT,
        FIN
    } hc_state_t;

endpackage

// File: rtl/card_bitmap_encoder.sv
// Lowest-index priority encoder over the deck bitmap.
// Also flags whether any bit, or more than one bit, is set.
module card_bitmap_encoder
    import card_pkg::*;
(
    input  logic [NUM_CARDS-1:0] vec,
    output logic [CARD_W-1:0]    idx,
    output logic                 any,
    output logic                 multi
);

    localparam logic [NUM_CARDS-1:0] ONE = NUM_CARDS'(1);

    always_comb begin
        idx = '0;
        for (int i = NUM_CARDS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CARD_W'(i);
            end
        end
    end

    assign any = |vec;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(vec & (vec - ONE));

endmodule

// File: rtl/card_hand_collector.sv
// Draws cards from the deck one at a time and streams their indices
// to game logic until a full hand is collected or the deck fails.
module card_hand_collector
    import card_pkg::*;
#(
    parameter int HAND_SIZE = 5,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_CARDS-1:0] dealt_cards,
    input  logic                 all_cards_dealt,
    output logic                 draw_card,
    output logic                 card_valid,
    input  logic                 card_ready,
    output logic [CARD_W-1:0]    card_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 short_hand,
    output logic                 err_timeout,
    output logic                 err_multi
);

    localparam int WCNT_W = $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [5:0] HAND_LAST = 6'(HAND_SIZE - 1);

    hc_state_t             state_q;
    logic [NUM_CARDS-1:0]  snap_q;
    logic [WCNT_W-1:0]     wcnt_q;
    logic [5:0]            count_q;
    logic [CARD_W-1:0]     idx_q;
    logic                  short_q;
    logic                  tmo_q;
    logic                  multi_q;

    logic [NUM_CARDS-1:0]  new_bits;
    logic [CARD_W-1:0]     new_idx;
    logic                  new_any;
    logic                  new_multi;

    // Bits cleared by a deck reset mid-hand can never appear as new.
    assign new_bits = dealt_cards & ~snap_q;

    card_bitmap_encoder u_enc (
        .vec   (new_bits),
        .idx   (new_idx),
        .any   (new_any),
        .multi (new_multi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            wcnt_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            short_q <= 1'b0;
            tmo_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        count_q <= '0;
                        short_q <= 1'b0;
                        tmo_q   <= 1'b0;
                        multi_q <= 1'b0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (all_cards_dealt) begin
                        short_q <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        snap_q  <= dealt_cards;
                        wcnt_q  <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (new_any) begin
                        idx_q <= new_idx;
                        if (new_multi) begin
                            multi_q <= 1'b1;
                        end
                        state_q <= EMIT;
                    end else if (all_cards_dealt) begin
                        short_q <= 1'b1;
                        state_q <= FIN;
                    end else if (wcnt_q == WCNT_LAST) begin
                        tmo_q   <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (card_ready) begin
                        count_q <= count_q + 6'd1;
                        if (count_q == HAND_LAST) begin
                            state_q <= FIN;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // No draw is issued in a REQ cycle that finds the deck exhausted.
    assign draw_card   = (state_q == REQ) && !all_cards_dealt;
    assign card_valid  = (state_q == EMIT);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign card_idx    = idx_q;
    assign short_hand  = short_q;
    assign err_timeout = tmo_q;
    assign err_multi   = multi_q;

endmodule

// File: tb/tb_card_hand_collector.sv
// Bench for card_hand_collector: behavioural deck, table vectors,
// random hands against a reference model, and reset corner cases.
module tb_card_hand_collector;
    import card_pkg::*;

    localparam int HAND = 5;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [53:0] dealt_cards = '0;
    logic        all_cards_dealt = 1'b0;
    logic        card_ready = 1'b0;
    logic        draw_card;
    logic        card_valid;
    logic [5:0]  card_idx;
    logic        busy;
    logic        done;
    logic        short_hand;
    logic        err_timeout;
    logic        err_multi;

    always #5 clk = ~clk;

    card_hand_collector #(
        .HAND_SIZE (HAND),
        .TIMEOUT   (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .dealt_cards     (dealt_cards),
        .all_cards_dealt (all_cards_dealt),
        .draw_card       (draw_card),
        .card_valid      (card_valid),
        .card_ready      (card_ready),
        .card_idx        (card_idx),
        .busy            (busy),
        .done            (done),
        .short_hand      (short_hand),
        .err_timeout     (err_timeout),
        .err_multi       (err_multi)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint got,
                       input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    function automatic logic [53:0] b(input int i);
        logic [53:0] one;
        one = 54'd1;
        return one << i;
    endfunction

    // Deck / consumer configuration, written by the stimulus process only
    logic [53:0] plan[$];
    int ex_at = 99;
    int pct = 100;
    int stall_card = -1;
    int stall_len = 0;
    int clr_req = 0;

    // Observations, written by the negedge process only
    int clr_seen = 0;
    bit pending = 0;
    int serviced = 0;
    int got[$];
    int draws = 0;
    int dones = 0;
    int hs_n = 0;
    int cyc = 0;
    int t_draw = 0;
    int t_done = 0;
    int t_vrise = 0;
    bit pv = 0;
    int stall_left = 0;
    bit stalling = 0;
    int st_idx[$];
    bit st_val[$];
    bit st_draw[$];

    // Behavioural deck: a draw seen in one cycle sets its planned bits
    // during the following cycle. Consumer ready is also generated here.
    always @(negedge clk) begin
        bit d;
        bit nr;
        logic [53:0] mask;
        cyc++;
        d = draw_card;
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            dealt_cards = '0;
            all_cards_dealt = 1'b0;
            serviced = 0;
            pending = 0;
            got.delete();
            draws = 0;
            dones = 0;
            hs_n = 0;
            t_draw = 0;
            t_done = 0;
            t_vrise = 0;
            stall_left = stall_len;
            stalling = 0;
            st_idx.delete();
            st_val.delete();
            st_draw.delete();
        end
        if (pending) begin
            mask = (serviced < plan.size()) ? plan[serviced] : '0;
            dealt_cards = dealt_cards | mask;
            serviced++;
            if (serviced == ex_at) all_cards_dealt = 1'b1;
        end
        pending = d;
        if (d) begin
            draws++;
            t_draw = cyc;
        end
        if (done) begin
            dones++;
            t_done = cyc;
        end
        if (card_valid && !pv) t_vrise = cyc;
        pv = card_valid;
        nr = ($urandom_range(1, 100) <= pct);
        if (!stalling && stall_left > 0 && card_valid &&
            hs_n == stall_card) stalling = 1;
        if (stalling && stall_left > 0) begin
            nr = 1'b0;
            stall_left--;
            st_idx.push_back(int'(card_idx));
            st_val.push_back(card_valid);
            st_draw.push_back(draw_card);
        end
        card_ready = nr;
        if (card_valid && nr) begin
            got.push_back(int'(card_idx));
            hs_n++;
        end
    end

    task automatic run_hand(output bit ok);
        clr_req++;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (dones > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference model: each draw yields the lowest genuinely new bit.
    task automatic model(input logic [53:0] pl[$], input int ex,
                         output int cards[$], output bit s,
                         output bit t, output bit m, output int nd);
        logic [53:0] seen;
        logic [53:0] mask;
        logic [53:0] nw;
        seen = '0;
        s = 0;
        t = 0;
        m = 0;
        nd = 0;
        cards.delete();
        for (int k = 0; k < 64; k++) begin
            if (k >= ex) begin
                s = 1;
                break;
            end
            nd++;
            mask = (k < pl.size()) ? pl[k] : '0;
            nw = mask & ~seen;
            seen = seen | mask;
            if (nw == '0) begin
                if (k + 1 >= ex) s = 1;
                else t = 1;
                break;
            end
            if ($countones(nw) > 1) m = 1;
            for (int i = 0; i < 54; i++) begin
                if (nw[i]) begin
                    cards.push_back(i);
                    break;
                end
            end
            if (cards.size() == HAND) break;
        end
    endtask

    function automatic int got_at(input int k);
        return (got.size() > k) ? got[k] : -1;
    endfunction

    typedef struct {
        logic [53:0] m[7];
        int n;
        int ex;
        int stall;
        int en;
        int ec[5];
        bit es;
        bit et;
        bit em;
        int ed;
    } vec_t;

    vec_t tv[6];

    initial begin
        bit ok;
        int ecards[$];
        bit es, et, em;
        int ed;
        logic [53:0] z;
        z = '0;

        tv[0] = '{m: '{b(7), b(0), b(53), b(12), b(30), z, z},
                  n: 5, ex: 99, stall: -1, en: 5,
                  ec: '{7, 0, 53, 12, 30},
                  es: 0, et: 0, em: 0, ed: 5};
        tv[1] = '{m: '{b(3), b(44), b(52), b(1), b(2), z, z},
                  n: 5, ex: 99, stall: 1, en: 5,
                  ec: '{3, 44, 52, 1, 2},
                  es: 0, et: 0, em: 0, ed: 5};
        tv[2] = '{m: '{b(10), b(20), b(5), z, z, z, z},
                  n: 3, ex: 3, stall: -1, en: 3,
                  ec: '{10, 20, 5, 0, 0},
                  es: 1, et: 0, em: 0, ed: 3};
        tv[3] = '{m: '{z, z, z, z, z, z, z},
                  n: 0, ex: 99, stall: -1, en: 0,
                  ec: '{0, 0, 0, 0, 0},
                  es: 0, et: 1, em: 0, ed: 1};
        tv[4] = '{m: '{b(4) | b(9), b(9) | b(21), b(33), b(40),
                       b(41), z, z},
                  n: 5, ex: 99, stall: -1, en: 5,
                  ec: '{4, 21, 33, 40, 41},
                  es: 0, et: 0, em: 1, ed: 5};
        tv[5] = '{m: '{z, z, z, z, z, z, z},
                  n: 1, ex: 1, stall: -1, en: 0,
                  ec: '{0, 0, 0, 0, 0},
                  es: 1, et: 0, em: 0, ed: 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_draw", draw_card, 0);
        chk("rst_valid", card_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_short", short_hand, 0);
        chk("rst_tmo", err_timeout, 0);
        chk("rst_multi", err_multi, 0);
        chk("rst_idx", card_idx, 0);

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            plan.delete();
            for (int k = 0; k < tv[v].n; k++) plan.push_back(tv[v].m[k]);
            ex_at = tv[v].ex;
            pct = 100;
            stall_card = tv[v].stall;
            stall_len = (tv[v].stall >= 0) ? 10 : 0;
            run_hand(ok);
            chk($sformatf("v%0d_done_seen", v), ok, 1);
            chk($sformatf("v%0d_done_cnt", v), dones, 1);
            chk($sformatf("v%0d_ncards", v), got.size(), tv[v].en);
            for (int k = 0; k < tv[v].en; k++)
                chk($sformatf("v%0d_card%0d", v, k), got_at(k),
                    tv[v].ec[k]);
            chk($sformatf("v%0d_short", v), short_hand, tv[v].es);
            chk($sformatf("v%0d_tmo", v), err_timeout, tv[v].et);
            chk($sformatf("v%0d_multi", v), err_multi, tv[v].em);
            chk($sformatf("v%0d_draws", v), draws, tv[v].ed);
            chk($sformatf("v%0d_busy", v), busy, 0);
            if (tv[v].stall >= 0) begin
                chk($sformatf("v%0d_stall_len", v), st_idx.size(), 10);
                for (int j = 0; j < st_idx.size(); j++) begin
                    chk($sformatf("v%0d_stall_idx%0d", v, j), st_idx[j],
                        tv[v].ec[tv[v].stall]);
                    chk($sformatf("v%0d_stall_val%0d", v, j), st_val[j], 1);
                    chk($sformatf("v%0d_stall_draw%0d", v, j),
                        st_draw[j], 0);
                end
            end
            if (v == 0)
                chk("draw_to_valid", t_vrise - t_draw, 2);
            if (v == 3)
                chk("timeout_cycles", t_done - t_draw, TMO + 1);
        end

        // Reset during EMIT of the second card
        plan.delete();
        for (int k = 1; k <= 5; k++) plan.push_back(b(k));
        ex_at = 99;
        pct = 100;
        stall_card = 1;
        stall_len = 1000;
        clr_req++;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (card_valid && hs_n == 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_reach_emit2", ok, 1);
        chk("mid_idx2", card_idx, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_draw", draw_card, 0);
        chk("mid_valid", card_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_idx", card_idx, 0);
        chk("mid_flags", {short_hand, err_timeout, err_multi}, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_no_done", dones, 0);
        chk("mid_idle", busy, 0);

        stall_card = -1;
        stall_len = 0;
        plan.delete();
        for (int k = 0; k < 5; k++) plan.push_back(tv[0].m[k]);
        run_hand(ok);
        chk("post_done_seen", ok, 1);
        chk("post_ncards", got.size(), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("post_card%0d", k), got_at(k), tv[0].ec[k]);

        // Random hands against the reference model
        for (int h = 0; h < 25; h++) begin
            plan.delete();
            for (int k = 0; k < 7; k++) begin
                int r;
                logic [53:0] mk;
                r = $urandom_range(0, 29);
                mk = '0;
                if (r != 0) mk = b($urandom_range(0, 53));
                if (r > 0 && r < 4) mk = mk | b($urandom_range(0, 53));
                plan.push_back(mk);
            end
            ex_at = $urandom_range(1, 9);
            pct = $urandom_range(40, 100);
            model(plan, ex_at, ecards, es, et, em, ed);
            run_hand(ok);
            chk($sformatf("r%0d_done_seen", h), ok, 1);
            chk($sformatf("r%0d_done_cnt", h), dones, 1);
            chk($sformatf("r%0d_ncards", h), got.size(), ecards.size());
            for (int k = 0; k < ecards.size(); k++)
                chk($sformatf("r%0d_card%0d", h, k), got_at(k), ecards[k]);
            chk($sformatf("r%0d_short", h), short_hand, es);
            chk($sformatf("r%0d_tmo", h), err_timeout, et);
            chk($sformatf("r%0d_multi", h), err_multi, em);
            chk($sformatf("r%0d_draws", h), draws, ed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
